bcd_to_binary_seq: RTL and testbench
====================================

Name: bcd_to_binary_seq

Overview:
- Sequential packed-BCD to unsigned-binary converter. It is the inverse of the team's binary-to-BCD double-dabble function.
- Uses reverse double-dabble: shift right one bit per cycle, then subtract 3 from each BCD digit that is >= 8.
- Converts decimal operands received over the UART command path (e.g. temperature alarm thresholds) into binary before they are written to ADT7420 registers.
- Simple start/done handshake with a one-cycle done pulse; the result is held until the next start.

Parameters:
- NUM_DIGITS, 8, number of BCD digits in the input (1..8).
- BIN_W, 27, binary result width. Must be >= ceil(3.3220*NUM_DIGITS); this is checked by an elaboration-time assertion.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion of bcd_in; sampled only in IDLE.
- bcd_in  input  4*NUM_DIGITS  packed BCD, digit 0 in bits [3:0].
- busy  output  1  high while a conversion is in progress (state != IDLE).
- done  output  1  one-cycle pulse when bin_out/err are valid.
- bin_out  output  BIN_W  converted value (BIN_W+1 wide when BCD_SIGN_EN).
- err  output  1  high if any input digit was > 9; valid with done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, bin_out=0, err=0, internal shift register and counter cleared. Deassertion takes effect at the next clk edge.
- Datapath: one register of width 4*NUM_DIGITS+BIN_W, BCD part on top and binary part below. Iteration counter width is clog2(BIN_W+1).
- IDLE:
  - On start=1, bcd_in is checked. If any nibble > 9: err<=1, bin_out<=0, go to DONE. No shifting occurs; latency is 1 cycle.
  - Otherwise: load {bcd_in, BIN_W'b0}, err<=0, count<=0, go to SHIFT.
- SHIFT, one iteration per cycle:
  - Logical right shift of the whole register by 1.
  - Then, for every BCD digit of the shifted value that is >= 8, subtract 3. All digits are corrected in parallel within the same cycle.
  - count increments. After BIN_W iterations: bin_out <= binary part, go to DONE. The BCD part is guaranteed zero at this point.
- DONE: done=1 for exactly one cycle, then return to IDLE. bin_out and err hold until the next accepted start.
- Latency: start sampled at edge t0 → done high in the cycle after edge t0+BIN_W+1, which is 28 cycles for the defaults.
- busy=1 from the edge that accepts start through the DONE cycle inclusive.
- start while busy: ignored, with no queuing and no effect on the conversion in progress.
- start held high continuously: a new conversion is accepted on the first IDLE cycle after DONE, giving back-to-back operation with one IDLE cycle between conversions.
- bcd_in is sampled only at acceptance; later changes have no effect.
- Reset mid-conversion: aborts immediately to the reset values, with no done pulse.
- Max input (all 9s) must not overflow BIN_W; this is guaranteed by the parameter constraint.

Optional Feature:
- Macro: BCD_SIGN_EN.
- Defined:
  - Adds input port sign_in (1 bit, 1=negative), sampled together with bcd_in at start.
  - bin_out becomes BIN_W+1 bits, two's complement. Negative results are negated in the DONE-entry cycle, so latency is unchanged.
  - Negative zero yields 0.
  - An invalid digit still gives err=1 and bin_out=0.
- Undefined: no sign_in port; bin_out is BIN_W bits unsigned. Behaviour is exactly as in the Behaviour section.

Test Plan:
- Reset then start with bcd_in=32'h00000000 → done after 28 cycles, bin_out=0, err=0, busy low the following cycle.
- bcd_in=32'h00001234 → bin_out=27'h00004D2. With BCD_SIGN_EN and sign_in=1 → bin_out=28'hFFFFB2E.
- bcd_in=32'h99999999 → bin_out=27'h5F5E0FF, err=0, done exactly 28 cycles after start.
- bcd_in=32'h0000001A → done on the cycle after start, err=1, bin_out=0. A following valid start with 32'h00000025 → err=0, bin_out=27'h19.
- Start with 32'h00000500, pulse start with 32'h00000007 at cycle 10 → single done, bin_out=27'h1F4. The second start is ignored.
- Start with 32'h00000500, assert rst_n=0 at cycle 12 → busy/done/bin_out/err all 0 immediately, no done pulse. The next conversion of 32'h00000042 → bin_out=27'h2A.

Source files
------------

// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential packed-BCD to binary converter (reverse double-dabble)
// Optional feature macro: BCD_SIGN_EN (adds sign_in, two's-complement bin_out of BIN_W+1 bits)
module bcd_to_binary_seq #(
  parameter int NUM_DIGITS = 8,
  parameter int BIN_W      = 27
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
`ifdef BCD_SIGN_EN
  input  logic                    sign_in,
  output logic [BIN_W:0]          bin_out,
`else
  output logic [BIN_W-1:0]        bin_out,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int BCD_W     = 4 * NUM_DIGITS;
  localparam int SR_W      = BCD_W + BIN_W;
  localparam int CNT_W     = $clog2(BIN_W + 1);
  // Minimum bits to hold 10^NUM_DIGITS-1, i.e. ceil(3.3220*NUM_DIGITS) in integer form
  localparam int MIN_BIN_W = (33220 * NUM_DIGITS + 9999) / 10000;
`ifdef BCD_SIGN_EN
  localparam int OUT_W     = BIN_W + 1;
`else
  localparam int OUT_W     = BIN_W;
`endif

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || BIN_W < MIN_BIN_W) begin : g_param_check
      $error("bcd_to_binary_seq: NUM_DIGITS must be 1..8 and BIN_W >= ceil(3.3220*NUM_DIGITS)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [SR_W-1:0]    sr_q;
  logic [SR_W-1:0]    sr_d;
  logic [SR_W-1:0]    sr_shift;
  logic [CNT_W-1:0]   cnt_q;
  logic [OUT_W-1:0]   bin_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               bad_digit;
`ifdef BCD_SIGN_EN
  logic               sign_q;
`endif

  // Flag any input nibble above 9; only meaningful in the accepting cycle
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  // One reverse double-dabble step: shift right, then pull every digit >= 8 down by 3
  always_comb begin
    sr_shift = sr_q >> 1;
    sr_d     = sr_shift;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sr_shift[BIN_W + 4*i +: 4] >= 4'd8) begin
        sr_d[BIN_W + 4*i +: 4] = sr_shift[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_SIGN_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (bad_digit) begin
              // Invalid operand: report immediately, nothing to shift
              err_q   <= 1'b1;
              bin_q   <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              sr_q    <= {bcd_in, {BIN_W{1'b0}}};
              err_q   <= 1'b0;
              cnt_q   <= '0;
              state_q <= SHIFT;
`ifdef BCD_SIGN_EN
              sign_q  <= sign_in;
`endif
            end
          end
        end
        SHIFT: begin
          if (cnt_q == CNT_W'(BIN_W)) begin
            // All bits have migrated into the binary part; BCD part is now zero
`ifdef BCD_SIGN_EN
            if (sign_q) begin
              bin_q <= -{1'b0, sr_q[BIN_W-1:0]};
            end else begin
              bin_q <= {1'b0, sr_q[BIN_W-1:0]};
            end
`else
            bin_q <= sr_q[BIN_W-1:0];
`endif
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb/tb_bcd_to_binary_seq.sv - self-checking bench for bcd_to_binary_seq (default build)
module tb_bcd_to_binary_seq;

  localparam int NUM_DIGITS = 8;
  localparam int BIN_W      = 27;
  localparam int LAT        = BIN_W + 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [4*NUM_DIGITS-1:0] bcd_in = '0;
  logic                    busy;
  logic                    done;
  logic [BIN_W-1:0]        bin_out;
  logic                    err;

  int checks = 0;
  int failures = 0;

  bcd_to_binary_seq #(.NUM_DIGITS(NUM_DIGITS), .BIN_W(BIN_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .bin_out(bin_out),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal value of a packed BCD word, computed digit by digit
  function automatic logic [BIN_W-1:0] dec_value(input logic [4*NUM_DIGITS-1:0] b);
    longint v = 0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v = v * 10 + longint'(b[4*i +: 4]);
    end
    return BIN_W'(v);
  endfunction

  function automatic logic has_bad_digit(input logic [4*NUM_DIGITS-1:0] b);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference model: a busy flag, a countdown to the done cycle and held results
  logic             m_busy = 1'b0;
  int               m_rem = 0;
  logic [BIN_W-1:0] m_bin = '0;
  logic [BIN_W-1:0] m_pend = '0;
  logic             m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_rem  = 0;
      m_bin  = '0;
      m_err  = 1'b0;
    end else if (m_busy) begin
      if (m_rem == 0) begin
        m_busy = 1'b0;
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_bin = m_pend;
      end
    end else if (start) begin
      m_busy = 1'b1;
      if (has_bad_digit(bcd_in)) begin
        m_rem = 0;
        m_bin = '0;
        m_err = 1'b1;
      end else begin
        m_rem  = LAT;
        m_pend = dec_value(bcd_in);
        m_err  = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_busy", 64'(busy), 64'(m_busy));
      check("cyc_done", 64'(done), 64'(m_busy && m_rem == 0));
      check("cyc_bin_out", 64'(bin_out), 64'(m_bin));
      check("cyc_err", 64'(err), 64'(m_err));
    end
  end

  // One conversion with hand-computed expectations; bcd_in is scrambled after acceptance
  task automatic convert(input logic [31:0] bcd, input logic [BIN_W-1:0] exp_bin,
                         input logic exp_err, input int exp_lat);
    int  lat;
    logic got;
    @(posedge clk); #1;
    start  = 1'b1;
    bcd_in = bcd;
    @(posedge clk); #1;
    start  = 1'b0;
    bcd_in = ~bcd;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("bin_out", 64'(bin_out), 64'(exp_bin));
    check("err", 64'(err), 64'(exp_err));
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    int n_done;
    int first;
    int second;
    int cyc;
    logic [BIN_W-1:0] captured;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_bin_out", 64'(bin_out), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    rst_n = 1'b1;

    check("model_1234", 64'(dec_value(32'h00001234)), 64'h4D2);
    check("model_max", 64'(dec_value(32'h99999999)), 64'h5F5E0FF);
    check("model_bad", 64'(has_bad_digit(32'h0000001A)), 64'd1);

    convert(32'h00000000, 27'h0, 1'b0, LAT);
    convert(32'h00001234, 27'h00004D2, 1'b0, LAT);
    convert(32'h99999999, 27'h5F5E0FF, 1'b0, LAT);
    convert(32'h0000001A, 27'h0, 1'b1, 0);
    convert(32'h00000025, 27'h19, 1'b0, LAT);
    convert(32'h00000001, 27'h1, 1'b0, LAT);

    // A start pulse mid-conversion must be ignored
    @(posedge clk); #1;
    start  = 1'b1;
    bcd_in = 32'h00000500;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start  = 1'b1;
    bcd_in = 32'h00000007;
    @(posedge clk); #1;
    start  = 1'b0;
    n_done   = 0;
    captured = '0;
    repeat (40) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        captured = bin_out;
      end
    end
    check("ignored_start_done_count", 64'(n_done), 64'd1);
    check("ignored_start_bin_out", 64'(captured), 64'h1F4);

    // Start held high: back-to-back conversions one IDLE cycle apart
    @(posedge clk); #1;
    start  = 1'b1;
    bcd_in = 32'h00000025;
    first  = -1;
    second = -1;
    cyc    = 0;
    while (second < 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_spacing", 64'(second - first), 64'(LAT + 2));
    check("b2b_bin_out", 64'(bin_out), 64'h19);

    // Reset mid-conversion aborts at once with no done pulse
    @(posedge clk); #1;
    start  = 1'b1;
    bcd_in = 32'h00000500;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_bin_out", 64'(bin_out), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);

    convert(32'h00000042, 27'h2A, 1'b0, LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
